// File: rtl/bist_sequencer_if.sv
// ----------------------------------------------------------------------------
// bist_sequencer_if
//
// Groups the BIST session signals shared by the sequencer and its surroundings.
// The request side (start/abort), the MISR feedback and the golden signature
// come from the system. The LFSR/adder/MISR strobes and the session status go
// back out.
//
//   master : system side. Drives start, abort, golden_sig and misr_sig.
//            Observes the strobes and the status.
//   slave  : the sequencer. Observes the requests and the signatures.
//            Drives lfsr_load, lfsr_en, dut_valid, misr_clr, misr_en, busy,
//            done, pass, pat_count and signature.
// ----------------------------------------------------------------------------
interface bist_sequencer_if #(
  parameter int PAT_CNT_W = 9,
  parameter int SIG_W     = 10
);
  // requests and signature inputs
  logic                 start;
  logic                 abort;
  logic [SIG_W-1:0]     golden_sig;
  logic [SIG_W-1:0]     misr_sig;

  // datapath strobes
  logic                 lfsr_load;
  logic                 lfsr_en;
  logic                 dut_valid;
  logic                 misr_clr;
  logic                 misr_en;

  // session status
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [PAT_CNT_W-1:0] pat_count;
  logic [SIG_W-1:0]     signature;

  modport master (
    output start, abort, golden_sig, misr_sig,
    input  lfsr_load, lfsr_en, dut_valid, misr_clr, misr_en,
    input  busy, done, pass, pat_count, signature
  );

  modport slave (
    input  start, abort, golden_sig, misr_sig,
    output lfsr_load, lfsr_en, dut_valid, misr_clr, misr_en,
    output busy, done, pass, pat_count, signature
  );
endinterface

// File: rtl/bist_sequencer.sv
// ----------------------------------------------------------------------------
// bist_sequencer
//
// Runs one BIST session over the shared pattern datapath (LFSRs, LFSR
// managers, adder, MISR). A session goes through these steps:
//   1. Seed the LFSRs and clear the MISR.
//   2. Issue NUM_PATTERNS patterns.
//   3. Let the adder pipeline drain into the MISR.
//   4. Capture the signature and compare it with golden_sig.
//
// States: IDLE -> SEED -> RUN -> FLUSH -> COMPARE -> DONE.
//   SEED lasts exactly 1 cycle.
//   RUN lasts exactly NUM_PATTERNS cycles.
//   FLUSH lasts PIPE_LAT cycles. When PIPE_LAT is 0 the FSM skips FLUSH.
//   COMPARE lasts exactly 1 cycle.
//   DONE holds until a new start or an abort.
// abort returns the FSM to IDLE from any state and wins over start.
//
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous reset, active high
//   bus : bist_sequencer_if.slave, which carries:
//         start, abort       session request / termination
//         golden_sig         expected signature, sampled in COMPARE
//         misr_sig           live MISR signature
//         lfsr_load          load seeds into all LFSRs (SEED)
//         lfsr_en            advance LFSRs and managers (RUN)
//         dut_valid          adder enable (RUN)
//         misr_clr           clear the MISR (SEED)
//         misr_en            lfsr_en delayed by PIPE_LAT cycles
//         busy               SEED, RUN, FLUSH or COMPARE
//         done               session complete (DONE)
//         pass               signature matched; meaningful while done=1
//         pat_count          patterns issued this session, saturates at N
//         signature          signature captured in COMPARE
//
// Every output is a flop or a decode of flops. No input reaches an output
// combinationally.
// ----------------------------------------------------------------------------
module bist_sequencer #(
  parameter int NUM_PATTERNS = 256,  // 1 .. 2**PAT_CNT_W-1
  parameter int PAT_CNT_W    = 9,
  parameter int PIPE_LAT     = 1,    // 0 .. 3
  parameter int SIG_W        = 10
) (
  input  logic          clk,
  input  logic          rst,
  bist_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_RUN,
    S_FLUSH,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam logic [PAT_CNT_W-1:0] LAST_PAT   = PAT_CNT_W'(NUM_PATTERNS - 1);
  localparam logic [PAT_CNT_W-1:0] MAX_PAT    = PAT_CNT_W'(NUM_PATTERNS);
  // Last value of the flush counter before moving on to COMPARE.
  localparam logic [1:0]           FLUSH_LAST = 2'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

  state_t               state_q, state_d;
  logic [PAT_CNT_W-1:0] pat_cnt_q;
  logic [1:0]           flush_cnt_q;
  logic                 pass_q;
  logic [SIG_W-1:0]     sig_q;

  logic                 enter_seed;
  logic                 lfsr_en_w;
  logic                 misr_en_w;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: clocked blocks use <= so every flop samples pre-edge values,
  // regardless of the order in which the blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // NOTE: state_d takes its hold value before the case statement, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:    if (bus.start) state_d = S_SEED;
        S_SEED:    state_d = S_RUN;
        S_RUN:     if (pat_cnt_q == LAST_PAT)
                     state_d = (PIPE_LAT == 0) ? S_COMPARE : S_FLUSH;
        S_FLUSH:   if (flush_cnt_q == FLUSH_LAST) state_d = S_COMPARE;
        S_COMPARE: state_d = S_DONE;
        S_DONE:    if (bus.start) state_d = S_SEED;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // SEED is reachable only from IDLE or DONE on start, never from itself.
  assign enter_seed = (state_d == S_SEED);

  // --------------------------------------------------------------------------
  // Pattern counter
  // --------------------------------------------------------------------------
  // The counter clears on the edge into SEED, so a restart from DONE already
  // shows 0 during SEED. It saturates at NUM_PATTERNS and never wraps inside
  // a session.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_cnt_q <= '0;
    end else if (bus.abort || enter_seed) begin
      pat_cnt_q <= '0;
    end else if (state_q == S_RUN && pat_cnt_q != MAX_PAT) begin
      pat_cnt_q <= pat_cnt_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Flush counter: counts the cycles spent in FLUSH. It holds 0 in every
  // other state.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_q <= '0;
    end else if (state_q == S_FLUSH && state_d == S_FLUSH) begin
      flush_cnt_q <= flush_cnt_q + 1'b1;
    end else begin
      flush_cnt_q <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Verdict and captured signature
  // --------------------------------------------------------------------------
  // pass clears on abort and on entry to SEED. It is set or cleared only by
  // COMPARE. An abort during COMPARE wins, so the capture is skipped and the
  // old signature stays.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q <= 1'b0;
      sig_q  <= '0;
    end else if (bus.abort || enter_seed) begin
      pass_q <= 1'b0;
    end else if (state_q == S_COMPARE) begin
      pass_q <= (bus.misr_sig == bus.golden_sig);
      sig_q  <= bus.misr_sig;
    end
  end

  // --------------------------------------------------------------------------
  // MISR enable: lfsr_en delayed by PIPE_LAT cycles
  // --------------------------------------------------------------------------
  assign lfsr_en_w = (state_q == S_RUN);

  generate
    if (PIPE_LAT == 0) begin : g_no_delay
      assign misr_en_w = lfsr_en_w;
    end else begin : g_delay
      logic [PIPE_LAT-1:0] dly_q;

      // NOTE: this delay line is control state, not storage. Like every
      // other flop it is reset, and it also clears on SEED and on abort, so
      // an aborted session leaves no stray compaction cycles behind.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dly_q <= '0;
        end else if (bus.abort || state_q == S_SEED) begin
          dly_q <= '0;
        end else begin
          dly_q[0] <= lfsr_en_w;
          for (int i = 1; i < PIPE_LAT; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      assign misr_en_w = dly_q[PIPE_LAT-1];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Outputs: decoded from state or taken straight from flops
  // --------------------------------------------------------------------------
  assign bus.lfsr_load = (state_q == S_SEED);
  assign bus.misr_clr  = (state_q == S_SEED);
  assign bus.lfsr_en   = lfsr_en_w;
  assign bus.dut_valid = lfsr_en_w;
  assign bus.misr_en   = misr_en_w;
  assign bus.busy      = (state_q == S_SEED)  || (state_q == S_RUN) ||
                         (state_q == S_FLUSH) || (state_q == S_COMPARE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.pass      = pass_q;
  assign bus.pat_count = pat_cnt_q;
  assign bus.signature = sig_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// ----------------------------------------------------------------------------
// tb_bist_sequencer
//
// The bench drives three sequencers from one shared set of start, abort and
// signature inputs:
//   A : N=256, PIPE_LAT=1 (default build)
//   B : N=256, PIPE_LAT=0 (no FLUSH state)
//   C : N=7,   PIPE_LAT=3 (short sessions, longest drain)
//
// The reference model describes a session only by the distance d, in cycles,
// from its SEED cycle:
//   d = -1          idle
//   d = 0           seed
//   d = 1..N        patterns issued
//   misr_en         high for d = 1+L .. N+L
//   d = N+L+1       compare
//   d = N+L+2       done, held
// All expected outputs are computed from d.
// ----------------------------------------------------------------------------
module tb_bist_sequencer;

  localparam int N_A = 256, L_A = 1;
  localparam int N_B = 256, L_B = 0;
  localparam int N_C = 7,   L_C = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_run = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [9:0] misr_sig = 10'h0;
  logic [9:0] golden_sig = 10'h0;

  int checks = 0;
  int errors = 0;

  bist_sequencer_if #(.PAT_CNT_W(9), .SIG_W(10)) if_a ();
  bist_sequencer_if #(.PAT_CNT_W(9), .SIG_W(10)) if_b ();
  bist_sequencer_if #(.PAT_CNT_W(9), .SIG_W(10)) if_c ();

  assign if_a.start = start;  assign if_a.abort = abort;
  assign if_a.misr_sig = misr_sig;  assign if_a.golden_sig = golden_sig;
  assign if_b.start = start;  assign if_b.abort = abort;
  assign if_b.misr_sig = misr_sig;  assign if_b.golden_sig = golden_sig;
  assign if_c.start = start;  assign if_c.abort = abort;
  assign if_c.misr_sig = misr_sig;  assign if_c.golden_sig = golden_sig;

  bist_sequencer #(.NUM_PATTERNS(N_A), .PAT_CNT_W(9), .PIPE_LAT(L_A), .SIG_W(10))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  bist_sequencer #(.NUM_PATTERNS(N_B), .PAT_CNT_W(9), .PIPE_LAT(L_B), .SIG_W(10))
    u_b (.clk(clk), .rst(rst), .bus(if_b));
  bist_sequencer #(.NUM_PATTERNS(N_C), .PAT_CNT_W(9), .PIPE_LAT(L_C), .SIG_W(10))
    u_c (.clk(clk), .rst(rst), .bus(if_c));

  // The clock can be stopped while low, so reset can be applied with no edge.
  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  typedef struct packed {
    int         d;
    logic       pass;
    logic [9:0] sig;
  } mstate_t;

  localparam mstate_t M_RESET = '{d: -1, pass: 1'b0, sig: 10'h0};

  mstate_t ma = M_RESET, mb = M_RESET, mc = M_RESET;

  function automatic mstate_t step(input mstate_t m, input int n, input int l,
                                   input logic st, input logic ab,
                                   input logic [9:0] ms, input logic [9:0] gs);
    mstate_t r = m;
    int d = m.d;
    int done_d = n + l + 2;
    if (ab) begin
      if (d != -1) begin
        r.d = -1;
        r.pass = 1'b0;
      end
    end else if (d == -1 || d == done_d) begin
      if (st) begin
        r.d = 0;
        r.pass = 1'b0;
      end
    end else begin
      if (d == n + l + 1) begin
        r.sig  = ms;
        r.pass = (ms == gs);
      end
      r.d = d + 1;
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= M_RESET;
      mb <= M_RESET;
      mc <= M_RESET;
    end else begin
      ma <= step(ma, N_A, L_A, start, abort, misr_sig, golden_sig);
      mb <= step(mb, N_B, L_B, start, abort, misr_sig, golden_sig);
      mc <= step(mc, N_C, L_C, start, abort, misr_sig, golden_sig);
    end
  end

  task automatic check_inst(input string tag, input mstate_t m, input int n, input int l,
                            input logic ld, input logic clr, input logic en, input logic dv,
                            input logic me, input logic bsy, input logic dn, input logic ps,
                            input logic [8:0] pc, input logic [9:0] sg);
    int d;
    int dd;
    int ep;
    d  = m.d;
    dd = n + l + 2;
    check({tag, " lfsr_load"}, 32'(ld),  32'(d == 0));
    check({tag, " misr_clr"},  32'(clr), 32'(d == 0));
    check({tag, " lfsr_en"},   32'(en),  32'(d >= 1 && d <= n));
    check({tag, " dut_valid"}, 32'(dv),  32'(d >= 1 && d <= n));
    check({tag, " misr_en"},   32'(me),  32'(d >= 1 + l && d <= n + l));
    check({tag, " busy"},      32'(bsy), 32'(d >= 0 && d <= n + l + 1));
    check({tag, " done"},      32'(dn),  32'(d == dd));
    check({tag, " signature"}, 32'(sg),  32'(m.sig));
    if (d == dd) check({tag, " pass"}, 32'(ps), 32'(m.pass));
    // The count shown during the seed cycle itself is left unchecked.
    if (d != 0) begin
      if (d == -1)      ep = 0;
      else if (d >= dd) ep = n;
      else              ep = (d - 1 < n) ? d - 1 : n;
      check({tag, " pat_count"}, 32'(pc), 32'(ep));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check_inst("A", ma, N_A, L_A, if_a.lfsr_load, if_a.misr_clr, if_a.lfsr_en, if_a.dut_valid,
                 if_a.misr_en, if_a.busy, if_a.done, if_a.pass, if_a.pat_count, if_a.signature);
      check_inst("B", mb, N_B, L_B, if_b.lfsr_load, if_b.misr_clr, if_b.lfsr_en, if_b.dut_valid,
                 if_b.misr_en, if_b.busy, if_b.done, if_b.pass, if_b.pat_count, if_b.signature);
      check_inst("C", mc, N_C, L_C, if_c.lfsr_load, if_c.misr_clr, if_c.lfsr_en, if_c.dut_valid,
                 if_c.misr_en, if_c.busy, if_c.done, if_c.pass, if_c.pat_count, if_c.signature);
    end
  end

  // --------------------------------------------------------------------------
  // Directed session with cycle bookkeeping (start is high in cycle 0)
  // --------------------------------------------------------------------------
  int ld_first, ld_cnt, en_first, en_cnt, me_first, me_cnt, meb_first, done_a_c, done_b_c;

  task automatic run_session(input int p0, input int p1);
    ld_first = -1; ld_cnt = 0; en_first = -1; en_cnt = 0;
    me_first = -1; me_cnt = 0; meb_first = -1; done_a_c = -1; done_b_c = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start = (c == p0 || c == p1);
      if (if_a.lfsr_load) begin if (ld_first < 0) ld_first = c; ld_cnt++; end
      if (if_a.lfsr_en)   begin if (en_first < 0) en_first = c; en_cnt++; end
      if (if_a.misr_en)   begin if (me_first < 0) me_first = c; me_cnt++; end
      if (if_b.misr_en && meb_first < 0) meb_first = c;
      if (if_a.done && done_a_c < 0) done_a_c = c;
      if (if_b.done && done_b_c < 0) done_b_c = c;
    end
    start = 1'b0;
  endtask

  initial begin
    bit found;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset A busy", 32'(if_a.busy), 32'd0);
    check("post-reset A done", 32'(if_a.done), 32'd0);

    // Matching signature; start pulses land in RUN (c=50) and in A's FLUSH (c=258).
    misr_sig = 10'h2A5; golden_sig = 10'h2A5;
    run_session(50, 258);
    check("T2 A lfsr_load first cycle", 32'(ld_first), 32'd1);
    check("T2 A lfsr_load cycles", 32'(ld_cnt), 32'd1);
    check("T2 A lfsr_en first cycle", 32'(en_first), 32'd2);
    check("T2 A lfsr_en cycles", 32'(en_cnt), 32'd256);
    check("T2 A misr_en first cycle", 32'(me_first), 32'd3);
    check("T2 A misr_en cycles", 32'(me_cnt), 32'd256);
    check("T2 B misr_en first cycle", 32'(meb_first), 32'd2);
    check("T2 A done cycle", 32'(done_a_c), 32'd260);
    check("T2 B done cycle", 32'(done_b_c), 32'd259);
    check("T2 A pass", 32'(if_a.pass), 32'd1);
    check("T2 A signature", 32'(if_a.signature), 32'h2A5);
    check("T2 A pat_count", 32'(if_a.pat_count), 32'd256);

    // Mismatching golden value; this session restarts from DONE.
    golden_sig = 10'h2A4;
    run_session(50, 258);
    check("T3 A done cycle", 32'(done_a_c), 32'd260);
    check("T3 A pass", 32'(if_a.pass), 32'd0);
    check("T3 A signature", 32'(if_a.signature), 32'h2A5);
    check("T3 B pass", 32'(if_b.pass), 32'd0);

    // Abort when pat_count reaches 100.
    golden_sig = 10'h2A5;
    @(negedge clk);
    start = 1'b1;
    found = 1'b0;
    for (int c = 1; c <= 400 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (if_a.lfsr_en && if_a.pat_count == 9'd100) found = 1'b1;
    end
    check("T4 reached pat_count 100", 32'(found), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("T4 A busy after abort", 32'(if_a.busy), 32'd0);
    check("T4 A lfsr_en after abort", 32'(if_a.lfsr_en), 32'd0);
    check("T4 A misr_en after abort", 32'(if_a.misr_en), 32'd0);
    check("T4 A done after abort", 32'(if_a.done), 32'd0);
    check("T4 A pat_count after abort", 32'(if_a.pat_count), 32'd0);
    run_session(-1, -1);
    check("T4 A done cycle after abort", 32'(done_a_c), 32'd260);
    check("T4 A pass", 32'(if_a.pass), 32'd1);
    check("T4 A pat_count", 32'(if_a.pat_count), 32'd256);

    // abort and start together while idle.
    @(negedge clk); abort = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("T6 A busy abort+start", 32'(if_a.busy), 32'd0);
    check("T6 A lfsr_load abort+start", 32'(if_a.lfsr_load), 32'd0);
    check("T6 B busy abort+start", 32'(if_b.busy), 32'd0);
    check("T6 B done abort+start", 32'(if_b.done), 32'd0);

    // Random traffic checked against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 7) == 0);
      abort    = ($urandom_range(0, 96) == 0);
      misr_sig = 10'($urandom);
      golden_sig = ($urandom_range(0, 1) == 0) ? misr_sig : 10'($urandom);
    end
    @(negedge clk); start = 1'b0; abort = 1'b0;

    // Asynchronous reset with the clock stopped, in the middle of a session.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    check("T1 A running before reset", 32'(if_a.lfsr_en), 32'd1);
    clk_run = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("T1 A lfsr_load in reset", 32'(if_a.lfsr_load), 32'd0);
    check("T1 A lfsr_en in reset", 32'(if_a.lfsr_en), 32'd0);
    check("T1 A dut_valid in reset", 32'(if_a.dut_valid), 32'd0);
    check("T1 A misr_clr in reset", 32'(if_a.misr_clr), 32'd0);
    check("T1 A misr_en in reset", 32'(if_a.misr_en), 32'd0);
    check("T1 A busy in reset", 32'(if_a.busy), 32'd0);
    check("T1 A done in reset", 32'(if_a.done), 32'd0);
    check("T1 A pass in reset", 32'(if_a.pass), 32'd0);
    check("T1 A pat_count in reset", 32'(if_a.pat_count), 32'd0);
    check("T1 A signature in reset", 32'(if_a.signature), 32'd0);
    check("T1 C misr_en in reset", 32'(if_c.misr_en), 32'd0);
    #5 rst = 1'b0;
    clk_run = 1'b1;
    @(negedge clk);
    check("T1 A busy after release", 32'(if_a.busy), 32'd0);
    check("T1 B busy after release", 32'(if_b.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
